// File: rtl/seq_hex_multiplier_if.sv
// rtl/seq_hex_multiplier_if.sv - operand/result bundle for the sequential hex multiplier
interface seq_hex_multiplier_if #(
    parameter int WIDTH = 4
);
    localparam int NDIG = (2 * WIDTH + 3) / 4;

    logic                   START;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   BUSY;
    logic                   DONE;
    logic [2*WIDTH-1:0]     PRODUCT;
    logic [7*NDIG-1:0]      HEX_SEG;

    modport master (
        output START, A, B,
        input  BUSY, DONE, PRODUCT, HEX_SEG
    );

    modport slave (
        input  START, A, B,
        output BUSY, DONE, PRODUCT, HEX_SEG
    );
endinterface

// File: rtl/seq_hex_multiplier.sv
// rtl/seq_hex_multiplier.sv - shift-add multiplier with start/done handshake and hex readout
module seq_hex_multiplier #(
    parameter int WIDTH  = 4,
    parameter int SIGNED = 0
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    seq_hex_multiplier_if.slave  bus
);
    localparam int NDIG = (2 * WIDTH + 3) / 4;
    localparam int PW   = 2 * WIDTH;
    localparam int CW   = $clog2(WIDTH);
    localparam int PAD  = 4 * NDIG - PW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t             r_state;
    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [PW-1:0]      r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_neg;
    logic               r_busy;
    logic               r_done;
    logic [PW-1:0]      r_product;

    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [4*NDIG-1:0]  w_ext;

    // abs of the most negative value wraps to the same bit pattern, which read unsigned is exact
    assign w_a_abs = ((SIGNED != 0) && bus.A[WIDTH-1]) ? (~bus.A + 1'b1) : bus.A;
    assign w_b_abs = ((SIGNED != 0) && bus.B[WIDTH-1]) ? (~bus.B + 1'b1) : bus.B;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.START) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_abs};
                        r_mplier <= w_b_abs;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_neg    <= (SIGNED != 0) && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_product <= r_neg ? (~r_acc + 1'b1) : r_acc;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.BUSY    = r_busy;
    assign bus.DONE    = r_done;
    assign bus.PRODUCT = r_product;

    // display is driven from the committed product only, never from partial sums
    generate
        if (PAD == 0) begin : g_no_pad
            assign w_ext = r_product;
        end else begin : g_pad
            logic w_fill;
            assign w_fill = (SIGNED != 0) ? r_product[PW-1] : 1'b0;
            assign w_ext  = {{PAD{w_fill}}, r_product};
        end
    endgenerate

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    generate
        for (genvar k = 0; k < NDIG; k++) begin : g_digit
            assign bus.HEX_SEG[7*k +: 7] = hex7(w_ext[4*k +: 4]);
        end
    endgenerate
endmodule

// File: tb/tb_seq_hex_multiplier.sv
// tb/tb_seq_hex_multiplier.sv - randomized bench for unsigned/signed 4-bit and unsigned 8-bit variants
module tb_seq_hex_multiplier;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, as4 = '0, bs4 = '0;
    logic [7:0] a8 = '0, b8 = '0;
    int n_total = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seq_hex_multiplier_if #(.WIDTH(4)) if_u4 ();
    seq_hex_multiplier_if #(.WIDTH(4)) if_s4 ();
    seq_hex_multiplier_if #(.WIDTH(8)) if_u8 ();

    assign if_u4.START = start;
    assign if_u4.A     = a4;
    assign if_u4.B     = b4;
    assign if_s4.START = start;
    assign if_s4.A     = as4;
    assign if_s4.B     = bs4;
    assign if_u8.START = start;
    assign if_u8.A     = a8;
    assign if_u8.B     = b8;

    seq_hex_multiplier #(.WIDTH(4), .SIGNED(0)) u_u4 (.CLOCK_50(clk), .RESET_N(rst_n), .bus(if_u4.slave));
    seq_hex_multiplier #(.WIDTH(4), .SIGNED(1)) u_s4 (.CLOCK_50(clk), .RESET_N(rst_n), .bus(if_s4.slave));
    seq_hex_multiplier #(.WIDTH(8), .SIGNED(0)) u_u8 (.CLOCK_50(clk), .RESET_N(rst_n), .bus(if_u8.slave));

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] exp_hex(input logic [15:0] p, input int ndig);
        logic [31:0] r;
        logic [3:0]  nib;
        r = '0;
        for (int k = 0; k < ndig; k++) begin
            nib = p[4*k +: 4];
            r[7*k +: 7] = SEG[nib];
        end
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy_u4"}, 32'(if_u4.BUSY), 32'd0);
        check({tag, "_busy_s4"}, 32'(if_s4.BUSY), 32'd0);
        check({tag, "_busy_u8"}, 32'(if_u8.BUSY), 32'd0);
        check({tag, "_prod_u4"}, 32'(if_u4.PRODUCT), 32'd0);
        check({tag, "_prod_s4"}, 32'(if_s4.PRODUCT), 32'd0);
        check({tag, "_prod_u8"}, 32'(if_u8.PRODUCT), 32'd0);
        check({tag, "_hex_u4"}, 32'(if_u4.HEX_SEG), exp_hex(16'h0, 2));
        check({tag, "_hex_u8"}, 32'(if_u8.HEX_SEG), exp_hex(16'h0, 4));
    endtask

    // one multiply on all three variants; a late START with scrambled operands must be ignored
    task automatic run_op(input logic [3:0] ua, input logic [3:0] ub,
                          input logic [3:0] sa, input logic [3:0] sb,
                          input logic [7:0] wa, input logic [7:0] wb);
        logic [7:0]  eu4, es4;
        logic [15:0] eu8;
        logic [31:0] tmp;
        int pa, pb;
        eu4 = 8'(int'(ua) * int'(ub));
        pa  = $signed(sa);
        pb  = $signed(sb);
        tmp = pa * pb;
        es4 = tmp[7:0];
        eu8 = 16'(int'(wa) * int'(wb));

        @(negedge clk);
        a4 = ua; b4 = ub; as4 = sa; bs4 = sb; a8 = wa; b8 = wb;
        start = 1'b1;
        for (int j = 0; j <= 9; j++) begin
            @(negedge clk);
            check("busy_u4", 32'(if_u4.BUSY), 32'(j <= 4));
            check("done_u4", 32'(if_u4.DONE), 32'(j == 5));
            check("busy_s4", 32'(if_s4.BUSY), 32'(j <= 4));
            check("done_s4", 32'(if_s4.DONE), 32'(j == 5));
            check("busy_u8", 32'(if_u8.BUSY), 32'(j <= 8));
            check("done_u8", 32'(if_u8.DONE), 32'(j == 9));
            if (j == 5 || j == 9) begin
                check("prod_u4", 32'(if_u4.PRODUCT), 32'(eu4));
                check("hex_u4", 32'(if_u4.HEX_SEG), exp_hex(16'(eu4), 2));
                check("prod_s4", 32'(if_s4.PRODUCT), 32'(es4));
                check("hex_s4", 32'(if_s4.HEX_SEG), exp_hex(16'(es4), 2));
            end
            if (j == 9) begin
                check("prod_u8", 32'(if_u8.PRODUCT), 32'(eu8));
                check("hex_u8", 32'(if_u8.HEX_SEG), exp_hex(eu8, 4));
            end
            if (j == 0) start = 1'b0;
            if (j == 2) begin
                a4 = 4'($urandom); b4 = 4'($urandom); as4 = 4'($urandom); bs4 = 4'($urandom);
                a8 = 8'($urandom); b8 = 8'($urandom);
                start = 1'b1;
            end
            if (j == 3) start = 1'b0;
        end
    endtask

    initial begin
        bit got_done;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_done_u4", 32'(if_u4.DONE), 32'd0);
        rst_n = 1'b1;

        run_op(4'd15, 4'd15, 4'h8, 4'h8, 8'hFF, 8'hFF);
        run_op(4'd0,  4'd9,  4'hD, 4'h5, 8'h00, 8'h37);
        run_op(4'd1,  4'd9,  4'h7, 4'hF, 8'h01, 8'h00);
        run_op(4'd7,  4'd0,  4'h0, 4'h8, 8'h80, 8'h80);
        for (int i = 0; i < 20; i++) begin
            run_op(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                   8'($urandom), 8'($urandom));
        end

        // START held high: exactly one non-busy cycle between DONE and the next run
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd5;
        start = 1'b1;
        got_done = 1'b0;
        for (int j = 0; j < 20 && !got_done; j++) begin
            @(negedge clk);
            if (if_u4.DONE) got_done = 1'b1;
        end
        check("hold_done_seen", 32'(got_done), 32'd1);
        check("hold_busy_at_done", 32'(if_u4.BUSY), 32'd0);
        @(negedge clk);
        check("hold_busy_restart", 32'(if_u4.BUSY), 32'd1);
        start = 1'b0;
        repeat (12) @(negedge clk);

        // reset mid-run discards the pending result
        a4 = 4'd9; b4 = 4'd9; as4 = 4'h3; bs4 = 4'h3; a8 = 8'd9; b8 = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            check("post_reset_no_done", 32'({if_u4.DONE, if_s4.DONE, if_u8.DONE}), 32'd0);
        end
        run_op(4'd12, 4'd11, 4'hA, 4'h6, 8'hC3, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
